// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux/demux pair: FSM state encoding and
// slot-index sizing.
package tdm_pkg;

    localparam int unsigned TDM_DEFAULT_CHANNELS = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    // Slot-index width for a frame of 'channels' slots (never narrower than 1 bit).
    function automatic int unsigned slot_w(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_counter.sv
// Slot index counter for the TDM demux: clear, load-to-1 and modulo increment.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned CHANNELS = TDM_DEFAULT_CHANNELS
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          clr_i,
    input  logic                          load_one_i,
    input  logic                          inc_i,
    output logic [slot_w(CHANNELS)-1:0]   cnt_o
);

    localparam int unsigned     W    = slot_w(CHANNELS);
    localparam logic [W-1:0]    LAST = W'(CHANNELS - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over load, load wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_one_i) begin
            cnt_d = W'(1);
        end else if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : tdm_slot_counter

// File: rtl/tdm_demux4.sv
// Serial TDM demultiplexer: locks on sync_in, collects one bit per slot and
// presents each complete frame as a parallel word with a one-cycle valid pulse.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned CHANNELS = TDM_DEFAULT_CHANNELS
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          sync_in,
    input  logic                          data_in,
    output logic [CHANNELS-1:0]           data_out,
    output logic                          valid_out,
    output logic [slot_w(CHANNELS)-1:0]   sel_out,
    output logic                          frame_err_out
);

    localparam int unsigned         SEL_W     = slot_w(CHANNELS);
    localparam logic [SEL_W-1:0]    LAST_SLOT = SEL_W'(CHANNELS - 1);

    tdm_state_e             state_q;
    tdm_state_e             state_d;

    logic [SEL_W-1:0]       slot;
    logic                   cnt_clr_c;
    logic                   cnt_load_c;
    logic                   cnt_inc_c;

    logic [CHANNELS-1:0]    partial_q;
    logic [CHANNELS-1:0]    partial_d;
    logic [CHANNELS-1:0]    word_q;
    logic [CHANNELS-1:0]    word_d;
    logic                   valid_q;
    logic                   valid_d;
    logic                   err_q;
    logic                   err_d;

    tdm_slot_counter #(
        .CHANNELS   (CHANNELS)
    ) u_slot_counter (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .clr_i      (cnt_clr_c),
        .load_one_i (cnt_load_c),
        .inc_i      (cnt_inc_c),
        .cnt_o      (slot)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock on sync; drop lock only when slot 0 arrives without sync.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sync_in) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!sync_in && (slot == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot capture, word hand-off and framing-error detection.
    always_comb begin
        partial_d  = partial_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        cnt_clr_c  = 1'b0;
        cnt_load_c = 1'b0;
        cnt_inc_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync_in) begin
                    partial_d  = CHANNELS'(data_in);
                    cnt_load_c = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (sync_in) begin
                    // Sync mid-frame restarts the frame on this cycle.
                    partial_d  = CHANNELS'(data_in);
                    cnt_load_c = 1'b1;
                    err_d      = (slot != '0);
                end else if (slot == '0) begin
                    partial_d  = '0;
                    cnt_clr_c  = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    partial_d[slot] = data_in;
                    cnt_inc_c       = 1'b1;
                    if (slot == LAST_SLOT) begin
                        word_d  = partial_d;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                partial_d = '0;
                cnt_clr_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            partial_q <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            partial_q <= partial_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign data_out      = word_q;
    assign valid_out     = valid_q;
    assign frame_err_out = err_q;
    assign sel_out       = slot;

    a_no_valid_err_overlap: assert property (
        @(posedge clk_in) disable iff (!rst_n_in) !(valid_out && frame_err_out));

    a_idle_sel_zero: assert property (
        @(posedge clk_in) disable iff (!rst_n_in) (state_q == ST_IDLE) |-> (sel_out == '0));

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed frames push expected valid/error
// events with their cycle; a monitor pops and compares on every output pulse.
`timescale 1ns/1ps
module tb_tdm_demux4;
    import tdm_pkg::*;

    localparam int unsigned CH = 4;
    localparam int unsigned SW = slot_w(CH);

    logic           clk_in   = 1'b0;
    logic           rst_n_in = 1'b1;
    logic           sync_in  = 1'b0;
    logic           data_in  = 1'b0;
    logic [CH-1:0]  data_out;
    logic           valid_out;
    logic [SW-1:0]  sel_out;
    logic           frame_err_out;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    typedef struct {
        bit             is_err;
        logic [CH-1:0]  word;
        int             at;
    } exp_t;

    exp_t expq[$];

    tdm_demux4 #(.CHANNELS(CH)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .sync_in       (sync_in),
        .data_in       (data_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .sel_out       (sel_out),
        .frame_err_out (frame_err_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input bit is_err, input logic [CH-1:0] word, input int at);
        exp_t x;
        x.is_err = is_err;
        x.word   = word;
        x.at     = at;
        expq.push_back(x);
    endtask

    // Present one slot; returns 1 ns after the sampling edge.
    task automatic step(input logic s, input logic d);
        sync_in = s;
        data_in = d;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [CH-1:0] w);
        for (int k = 0; k < int'(CH); k++) step(k == 0, w[k]);
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clk_in);
            if (valid_out || frame_err_out) begin
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_event: valid=%0b err=%0b data=%0h at cycle %0d, expected none",
                             valid_out, frame_err_out, data_out, cyc);
                end else begin
                    x = expq.pop_front();
                    check("event_kind", 32'({valid_out, frame_err_out}), x.is_err ? 32'h1 : 32'h2);
                    check("event_cycle", 32'(cyc), 32'(x.at));
                    if (!x.is_err) check("event_word", 32'(data_out), 32'(x.word));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Asynchronous reset before any clock edge
        #2 rst_n_in = 1'b0;
        #1;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_sel", 32'(sel_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_err", 32'(frame_err_out), 32'h0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Idle stream without sync: nothing happens
        for (int i = 0; i < 6; i++) begin
            step(1'b0, i[0]);
            check("idle_sel", 32'(sel_out), 32'h0);
        end

        // First frame 1,0,1,1 -> 4'b1101
        push(1'b0, 4'b1101, cyc + 4);
        step(1'b1, 1'b1);
        check("f1_sel1", 32'(sel_out), 32'h1);
        step(1'b0, 1'b0);
        check("f1_sel2", 32'(sel_out), 32'h2);
        step(1'b0, 1'b1);
        check("f1_sel3", 32'(sel_out), 32'h3);
        step(1'b0, 1'b1);
        check("f1_sel_wrap", 32'(sel_out), 32'h0);
        check("f1_data", 32'(data_out), 32'hD);

        // Back-to-back frames
        push(1'b0, 4'b0011, cyc + 4);
        push(1'b0, 4'b1010, cyc + 8);
        send_frame(4'b0011);
        send_frame(4'b1010);
        check("b2b_data", 32'(data_out), 32'hA);

        // Sync at slot 2: error, resync, word 0,1,1,0 -> 4'b0110
        push(1'b1, '0, cyc + 3);
        push(1'b0, 4'b0110, cyc + 6);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("partial_hidden", 32'(data_out), 32'hA);
        step(1'b1, 1'b0);
        check("resync_sel", 32'(sel_out), 32'h1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("resync_data", 32'(data_out), 32'h6);

        // Missing sync at slot 0: error, unlock, then ignore 8 cycles
        push(1'b1, '0, cyc + 1);
        step(1'b0, 1'b1);
        check("unlock_sel", 32'(sel_out), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, ~i[0]);
            check("unlocked_sel", 32'(sel_out), 32'h0);
        end
        check("unlocked_hold", 32'(data_out), 32'h6);

        // Reset pulse between edges while at slot 2
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check("pre_rst_sel", 32'(sel_out), 32'h2);
        #2 rst_n_in = 1'b0;
        #0.5;
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_sel", 32'(sel_out), 32'h0);
        check("mid_rst_valid", 32'(valid_out), 32'h0);
        check("mid_rst_err", 32'(frame_err_out), 32'h0);
        #0.5 rst_n_in = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("post_rst_sel", 32'(sel_out), 32'h0);
        push(1'b0, 4'b1001, cyc + 4);
        send_frame(4'b1001);

        @(negedge clk_in);
        #1;
        check("queue_drained", 32'(expq.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_tdm_demux4
